// File: rtl/calc_ctrl.sv
// Command sequencer between the UART parser and the calculator ALU.
// Launches the ALU, bounds the wait, and streams the result as hex + CR LF.
module calc_ctrl #(
    parameter int RES_W   = 32,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             dec_done,
    input  logic [3:0]       dtype,
    input  logic [4:0]       op,
    input  logic [15:0]      src1,
    input  logic [15:0]      src2,
    output logic             alu_start,
    output logic [4:0]       alu_op,
    output logic             alu_signed,
    output logic [15:0]      alu_a,
    output logic [15:0]      alu_b,
    input  logic             alu_done,
    input  logic             alu_err,
    input  logic [RES_W-1:0] alu_result,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic [7:0]       drop_cnt
);

    localparam int NIB = RES_W / 4;
    localparam int IW  = $clog2(NIB + 2);
    localparam int TW  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_ALU,
        SEND
    } state_t;

    state_t           state;
    logic [RES_W-1:0] res;
    logic             err;
    logic [IW-1:0]    idx;
    logic [TW-1:0]    timer;
    logic             cmd_ok;
    logic             last;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h57 + {4'h0, n};
    endfunction

    // Character i of the frame for a given result/error pair.
    function automatic logic [7:0] char_at(
        input logic [RES_W-1:0] r,
        input logic             e,
        input logic [IW-1:0]    i
    );
        logic [RES_W-1:0] sh;
        logic [7:0]       c;
        sh = '0;
        c  = 8'h0a;
        if (e) begin
            if (i == IW'(0))
                c = 8'h45;
            else if (i == IW'(1))
                c = 8'h0d;
        end else if (i < IW'(NIB)) begin
            sh = r >> (4 * (NIB - 1 - int'(i)));
            c  = hex_char(sh[3:0]);
        end else if (i == IW'(NIB)) begin
            c = 8'h0d;
        end
        return c;
    endfunction

    assign cmd_ok = (dtype == 4'h1 || dtype == 4'h2) &&
                    (op == 5'h01 || op == 5'h02 ||
                     op == 5'h04 || op == 5'h08);

    assign last = err ? (idx == IW'(2)) : (idx == IW'(NIB + 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            alu_start  <= 1'b0;
            alu_op     <= '0;
            alu_signed <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            tx_valid   <= 1'b0;
            tx_data    <= 8'h00;
            drop_cnt   <= 8'h00;
            res        <= '0;
            err        <= 1'b0;
            idx        <= '0;
            timer      <= '0;
        end else begin
            alu_start <= 1'b0;
            if (dec_done && state != IDLE && drop_cnt != 8'hff)
                drop_cnt <= drop_cnt + 8'd1;

            unique case (state)
                IDLE: begin
                    if (dec_done) begin
                        alu_op     <= op;
                        alu_signed <= (dtype == 4'h2);
                        alu_a      <= src1;
                        alu_b      <= src2;
                        idx        <= '0;
                        if (cmd_ok) begin
                            err       <= 1'b0;
                            alu_start <= 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            err      <= 1'b1;
                            tx_valid <= 1'b1;
                            tx_data  <= 8'h45;
                            state    <= SEND;
                        end
                    end
                end
                LAUNCH: begin
                    timer <= '0;
                    state <= WAIT_ALU;
                end
                WAIT_ALU: begin
                    if (alu_done) begin
                        res      <= alu_result;
                        err      <= alu_err;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= char_at(alu_result, alu_err, '0);
                        state    <= SEND;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        idx      <= '0;
                        tx_valid <= 1'b1;
                        tx_data  <= 8'h45;
                        state    <= SEND;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (last) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            idx     <= idx + IW'(1);
                            tx_data <= char_at(res, err, idx + IW'(1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed bench for calc_ctrl: frame scoreboard from a string-level model,
// plus literal frame pins, latency, timeout, drop and reset checks.
module tb_calc_ctrl;

    localparam int RES_W   = 32;
    localparam int TIMEOUT = 64;

    logic             clk;
    logic             n_rst;
    logic             dec_done;
    logic [3:0]       dtype;
    logic [4:0]       op;
    logic [15:0]      src1;
    logic [15:0]      src2;
    logic             alu_start;
    logic [4:0]       alu_op;
    logic             alu_signed;
    logic [15:0]      alu_a;
    logic [15:0]      alu_b;
    logic             alu_done;
    logic             alu_err;
    logic [RES_W-1:0] alu_result;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic [7:0]       drop_cnt;

    calc_ctrl #(.RES_W(RES_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst), .dec_done(dec_done), .dtype(dtype),
        .op(op), .src1(src1), .src2(src2), .alu_start(alu_start),
        .alu_op(alu_op), .alu_signed(alu_signed), .alu_a(alu_a),
        .alu_b(alu_b), .alu_done(alu_done), .alu_err(alu_err),
        .alu_result(alu_result), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    byte unsigned exp_q[$];
    string       rx = "";
    int          xfers = 0;
    int          nstart = 0;
    bit          stall = 0;
    int          scnt = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic string hexs(input string s);
        string h = "";
        for (int i = 0; i < s.len(); i++)
            h = {h, $sformatf("%02h ", s[i])};
        return h;
    endfunction

    task automatic check_str(input string name, input string act,
                             input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got [%s] expected [%s]", name, hexs(act),
                     hexs(exp));
        end
    endtask

    // Model: the frame the UART must see for a command and its ALU outcome.
    function automatic bit cmd_valid(input logic [3:0] dt, input logic [4:0] o);
        return (dt inside {4'h1, 4'h2}) &&
               (o inside {5'h01, 5'h02, 5'h04, 5'h08});
    endfunction

    function automatic string frame(input logic [3:0] dt, input logic [4:0] o,
                                    input bit done, input bit aerr,
                                    input logic [31:0] r);
        if (!cmd_valid(dt, o) || !done || aerr)
            return "E\015\012";
        return $sformatf("%h\015\012", r);
    endfunction

    task automatic push_frame(input string f);
        for (int i = 0; i < f.len(); i++)
            exp_q.push_back(f[i]);
    endtask

    // TX back-pressure: in stall mode ready is low 5 of every 6 cycles.
    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall) begin
                scnt++;
                tx_ready = (scnt % 6 == 0);
            end else begin
                tx_ready = 1'b1;
            end
        end
    end

    // Compare process: every accepted byte against the model queue.
    initial begin
        logic       prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (alu_start)
                nstart++;
            if (n_rst) begin
                if (prev_hold) begin
                    check("stall_valid", {31'd0, tx_valid}, 32'd1);
                    check("stall_data", {24'd0, tx_data}, {24'd0, prev_data});
                end
                if (tx_valid && tx_ready) begin
                    xfers++;
                    rx = {rx, $sformatf("%c", tx_data)};
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte: got %02h expected none",
                                 tx_data);
                    end else begin
                        check("tx_byte", {24'd0, tx_data},
                              {24'd0, exp_q.pop_front()});
                    end
                end
                prev_hold = tx_valid && !tx_ready;
                prev_data = tx_data;
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("idle_bound", {31'd0, busy}, 32'd0);
        @(negedge clk);
    endtask

    task automatic run_cmd(input logic [3:0] dt, input logic [4:0] o,
                           input logic [15:0] a, input logic [15:0] b,
                           input bit do_alu, input logic [31:0] r,
                           input bit aerr, input int ndrop);
        int         st0;
        logic [7:0] d0;
        bit         ok;
        st0 = nstart;
        d0  = drop_cnt;
        ok  = cmd_valid(dt, o);
        rx  = "";
        push_frame(frame(dt, o, do_alu, aerr, r));
        @(posedge clk); #1;
        dec_done = 1'b1; dtype = dt; op = o; src1 = a; src2 = b;
        @(posedge clk); #1;
        dec_done = 1'b0;
        @(negedge clk);
        if (ok) begin
            check("launch", {31'd0, alu_start}, 32'd1);
            check("alu_a", {16'd0, alu_a}, {16'd0, a});
            check("alu_b", {16'd0, alu_b}, {16'd0, b});
            check("alu_op", {27'd0, alu_op}, {27'd0, o});
            check("alu_signed", {31'd0, alu_signed}, {31'd0, dt == 4'h2});
        end else begin
            check("err_latency", {31'd0, tx_valid}, 32'd1);
            check("no_start", {31'd0, alu_start}, 32'd0);
        end
        if (ok && do_alu) begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            alu_done = 1'b1; alu_result = r; alu_err = aerr;
            @(posedge clk); #1;
            alu_done = 1'b0; alu_err = 1'b0;
            @(negedge clk);
            check("res_latency", {31'd0, tx_valid}, 32'd1);
        end
        if (ok && !do_alu) begin
            repeat (TIMEOUT) @(negedge clk);
            check("timeout_early", {31'd0, tx_valid}, 32'd0);
            @(negedge clk);
            check("timeout_at", {31'd0, tx_valid}, 32'd1);
        end
        for (int k = 0; k < ndrop; k++) begin
            @(posedge clk); #1;
            dec_done = 1'b1; dtype = 4'h1; op = 5'h01;
            src1 = 16'hdead; src2 = 16'hbeef;
            @(posedge clk); #1;
            dec_done = 1'b0;
        end
        wait_idle();
        check("frame_len", exp_q.size(), 32'd0);
        check("start_cnt", nstart - st0, ok ? 32'd1 : 32'd0);
        check("drop_cnt", {24'd0, drop_cnt}, {24'd0, d0} + ndrop);
        check("a_held", {16'd0, alu_a}, {16'd0, a});
        if (ok && !do_alu) begin
            @(posedge clk); #1;
            alu_done = 1'b1; alu_result = 32'h1234;
            @(posedge clk); #1;
            alu_done = 1'b0;
            @(negedge clk);
            check("late_busy", {31'd0, busy}, 32'd0);
            check("late_tx", {31'd0, tx_valid}, 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int x0;
        int n;
        n_rst = 1'b0; dec_done = 1'b0; dtype = '0; op = '0;
        src1 = '0; src2 = '0; alu_done = 1'b0; alu_err = 1'b0;
        alu_result = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_start", {31'd0, alu_start}, 32'd0);
        check("rst_a", {16'd0, alu_a}, 32'd0);
        check("rst_b", {16'd0, alu_b}, 32'd0);
        check("rst_op", {27'd0, alu_op}, 32'd0);
        check("rst_signed", {31'd0, alu_signed}, 32'd0);
        check("rst_drop", {24'd0, drop_cnt}, 32'd0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        run_cmd(4'h1, 5'h01, 16'h0012, 16'h0034, 1, 32'h00000046, 0, 0);
        check_str("t1_frame", rx, "00000046\015\012");

        stall = 1;
        run_cmd(4'h2, 5'h02, 16'h0005, 16'h0007, 1, 32'hfffffffe, 0, 0);
        stall = 0;
        check_str("t2_frame", rx, "fffffffe\015\012");

        run_cmd(4'h1, 5'h10, 16'h0001, 16'h0002, 1, 32'h0, 0, 0);
        check_str("t3_bad_op", rx, "E\015\012");
        run_cmd(4'h3, 5'h01, 16'h0003, 16'h0004, 1, 32'h0, 0, 0);
        check_str("t3_bad_type", rx, "E\015\012");

        run_cmd(4'h1, 5'h04, 16'h0003, 16'h0004, 0, 32'h0, 0, 0);
        check_str("t4_timeout", rx, "E\015\012");

        stall = 1;
        run_cmd(4'h1, 5'h08, 16'h0009, 16'h0000, 1, 32'h0, 1, 3);
        stall = 0;
        check_str("t5_alu_err", rx, "E\015\012");
        check("t5_drops", {24'd0, drop_cnt}, 32'd3);

        rx = "";
        push_frame(frame(4'h1, 5'h01, 1, 0, 32'h89abcdef));
        @(posedge clk); #1;
        dec_done = 1'b1; dtype = 4'h1; op = 5'h01;
        src1 = 16'h0001; src2 = 16'h0002;
        @(posedge clk); #1;
        dec_done = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        alu_done = 1'b1; alu_result = 32'h89abcdef;
        @(posedge clk); #1;
        alu_done = 1'b0;
        x0 = xfers;
        n = 0;
        while (xfers < x0 + 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_idx4", xfers - x0, 32'd4);
        check_str("t6_partial", rx, "89ab");
        @(posedge clk); #2;
        n_rst = 1'b0;
        #1;
        check("t6_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_drop", {24'd0, drop_cnt}, 32'd0);
        check("t6_a", {16'd0, alu_a}, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        n_rst = 1'b1;

        run_cmd(4'h1, 5'h01, 16'h00ff, 16'h0001, 1, 32'h00000100, 0, 0);
        check_str("t6_after", rx, "00000100\015\012");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
